// File: rtl/exe_div_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exe_div_sequencer_pkg
//  Description : Shared constants for the EXE-stage divider. This covers the
//                default datapath width and the sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package exe_div_sequencer_pkg;

    localparam int DIV_WD = 32;

    typedef logic [1:0] div_state_t;

    localparam div_state_t DIV_ST_IDLE = 2'd0;
    localparam div_state_t DIV_ST_CALC = 2'd1;
    localparam div_state_t DIV_ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/exe_div_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : exe_div_sequencer_if
//  Description : EXE <-> divider bundle. The master side (EXE) drives the
//                request, consume and flush signals. The slave side (the
//                divider) drives the handshake and the result.
//  Signals     : div_in_valid/div_in_ready   request handshake
//                div_signed, div_src1/2      operation and operands
//                div_out_valid/div_out_ready result handshake
//                div_quotient/div_remainder  registered results
//                div_busy                    stall request towards EXE
//                div_flush                   pipeline kill
//  Revision    : 1.0  initial release
// ============================================================================
interface exe_div_sequencer_if
    import exe_div_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_WD
);
    logic                  div_in_valid;
    logic                  div_in_ready;
    logic                  div_signed;
    logic [DATA_WIDTH-1:0] div_src1;
    logic [DATA_WIDTH-1:0] div_src2;
    logic                  div_out_valid;
    logic                  div_out_ready;
    logic [DATA_WIDTH-1:0] div_quotient;
    logic [DATA_WIDTH-1:0] div_remainder;
    logic                  div_busy;
    logic                  div_flush;

    modport master (
        output div_in_valid, div_signed, div_src1, div_src2, div_out_ready, div_flush,
        input  div_in_ready, div_out_valid, div_quotient, div_remainder, div_busy
    );

    modport slave (
        input  div_in_valid, div_signed, div_src1, div_src2, div_out_ready, div_flush,
        output div_in_ready, div_out_valid, div_quotient, div_remainder, div_busy
    );
endinterface
`default_nettype wire

// File: rtl/exe_div_sequencer_div_iter_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter_step
//  Description : One radix-2 restoring division step. It is purely
//                combinational. The {rem,quo} pair is shifted left by one,
//                and the divisor is trial-subtracted from the widened partial
//                remainder. The new quotient LSB is set when no borrow occurs.
//  Ports       : i_rem, i_quo  current partial remainder / quotient register
//                i_dvs         unsigned divisor magnitude
//                o_rem, o_quo  updated pair
//  Revision    : 1.0  initial release
// ============================================================================
module div_iter_step #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic [DATA_WIDTH-1:0] i_rem,
    input  wire logic [DATA_WIDTH-1:0] i_quo,
    input  wire logic [DATA_WIDTH-1:0] i_dvs,
    output logic      [DATA_WIDTH-1:0] o_rem,
    output logic      [DATA_WIDTH-1:0] o_quo
);
    // The shifted remainder needs one extra bit, because i_rem < i_dvs can
    // still reach 2*i_dvs-1. A second extra bit carries the borrow.
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH+1:0] w_diff;
    logic                  w_borrow;
    logic                  w_unused_diff_bit;

    assign w_shift           = {i_rem, i_quo[DATA_WIDTH-1]};
    assign w_diff            = {1'b0, w_shift} - {2'b00, i_dvs};
    assign w_borrow          = w_diff[DATA_WIDTH+1];
    // On success the difference is below the divisor, so this bit is always zero.
    assign w_unused_diff_bit = w_diff[DATA_WIDTH];

    assign o_rem = w_borrow ? w_shift[DATA_WIDTH-1:0] : w_diff[DATA_WIDTH-1:0];
    assign o_quo = {i_quo[DATA_WIDTH-2:0], ~w_borrow};
endmodule
`default_nettype wire

// File: rtl/exe_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : exe_div_sequencer
//  Description : Multi-cycle DIV/DIVU unit for the EXE stage. Operands are
//                latched as magnitudes, and DATA_WIDTH restoring steps run
//                through div_iter_step. Signs are fixed up on entry to DONE,
//                and the results are held until EXE consumes them. A flush
//                or reset aborts the operation in flight.
//  Ports       : clk, reset (sync, active-high)
//                bus  exe_div_sequencer_if.slave  (handshake, operands, result)
//  Config      : DIV_EARLY_OUT_EN  skip the iterations when the divisor is
//                zero or |dividend| < |divisor|. Results are bit-identical.
//  Revision    : 1.0  initial release
// ============================================================================
module exe_div_sequencer
    import exe_div_sequencer_pkg::*;
#(
    parameter  int DATA_WIDTH = DIV_WD,
    localparam int CNT_WD     = $clog2(DATA_WIDTH) + 1
) (
    input  wire logic            clk,
    input  wire logic            reset,
    exe_div_sequencer_if.slave   bus
);
    localparam logic [CNT_WD-1:0] c_CNT_LAST = CNT_WD'(DATA_WIDTH - 1);

    div_state_t            r_state;
    div_state_t            w_nxt_state;
    logic [CNT_WD-1:0]     r_cnt;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_dvs;
    logic                  r_sign_q;
    logic                  r_sign_r;
    logic [DATA_WIDTH-1:0] r_quotient;
    logic [DATA_WIDTH-1:0] r_remainder;

    logic                  w_neg1;
    logic                  w_neg2;
    logic [DATA_WIDTH-1:0] w_abs1;
    logic [DATA_WIDTH-1:0] w_abs2;
    logic                  w_sign_q_in;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_early;
    logic [DATA_WIDTH-1:0] w_early_q;
    logic [DATA_WIDTH-1:0] w_step_rem;
    logic [DATA_WIDTH-1:0] w_step_quo;

    // Operand magnitudes. Negating MIN_INT wraps to 2^(W-1), which is the correct unsigned magnitude.
    assign w_neg1      = bus.div_signed & bus.div_src1[DATA_WIDTH-1];
    assign w_neg2      = bus.div_signed & bus.div_src2[DATA_WIDTH-1];
    assign w_abs1      = w_neg1 ? (~bus.div_src1 + 1'b1) : bus.div_src1;
    assign w_abs2      = w_neg2 ? (~bus.div_src2 + 1'b1) : bus.div_src2;
    assign w_sign_q_in = w_neg1 ^ w_neg2;

    assign w_accept = (r_state == DIV_ST_IDLE) & bus.div_in_valid & ~bus.div_flush;
    assign w_last   = (r_cnt == c_CNT_LAST);

`ifdef DIV_EARLY_OUT_EN
    // The zero divisor yields all ones before the fix-up. A small dividend yields quotient zero.
    assign w_early   = (bus.div_src2 == '0) | (w_abs1 < w_abs2);
    assign w_early_q = (bus.div_src2 == '0) ? (w_sign_q_in ? DATA_WIDTH'(1) : '1) : '0;
`else
    assign w_early   = 1'b0;
    assign w_early_q = '0;
`endif

    div_iter_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= DIV_ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next-state logic. A flush outranks both accept and consume.
    always_comb begin
        w_nxt_state = r_state;
        if (bus.div_flush) begin
            w_nxt_state = DIV_ST_IDLE;
        end else begin
            case (r_state)
                DIV_ST_IDLE: if (bus.div_in_valid) w_nxt_state = w_early ? DIV_ST_DONE : DIV_ST_CALC;
                DIV_ST_CALC: if (w_last)           w_nxt_state = DIV_ST_DONE;
                DIV_ST_DONE: if (bus.div_out_ready) w_nxt_state = DIV_ST_IDLE;
                default:                           w_nxt_state = DIV_ST_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.div_in_ready  = (r_state == DIV_ST_IDLE);
        bus.div_out_valid = (r_state == DIV_ST_DONE);
        bus.div_busy      = (r_state == DIV_ST_CALC) | ((r_state == DIV_ST_IDLE) & bus.div_in_valid);
        bus.div_quotient  = r_quotient;
        bus.div_remainder = r_remainder;
    end

    // Datapath. The operands are sampled only at accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= w_abs1;
            r_dvs    <= w_abs2;
            r_sign_q <= w_sign_q_in;
            r_sign_r <= w_neg1;
            if (w_early) begin
                r_quotient  <= w_early_q;
                r_remainder <= bus.div_src1;
            end
        end else if ((r_state == DIV_ST_CALC) && !bus.div_flush) begin
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
            r_cnt <= r_cnt + CNT_WD'(1);
            if (w_last) begin
                r_quotient  <= r_sign_q ? (~w_step_quo + 1'b1) : w_step_quo;
                r_remainder <= r_sign_r ? (~w_step_rem + 1'b1) : w_step_rem;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_exe_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exe_div_sequencer
//  Description : Directed and random checks of exe_div_sequencer (32-bit).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exe_div_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exe_div_sequencer_if #(.DATA_WIDTH(W)) bus ();

    exe_div_sequencer #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents an op at a negedge. The task returns at the negedge after the accepting posedge.
    task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.div_in_valid = 1'b1;
        bus.div_signed   = sgn;
        bus.div_src1     = a;
        bus.div_src2     = b;
        @(posedge clk);
        @(negedge clk);
        bus.div_in_valid = 1'b0;
        bus.div_src1     = $urandom;   // must be ignored after accept
        bus.div_src2     = $urandom;
    endtask

    // Counts posedges after accept until div_out_valid rises. The wait is bounded.
    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (lat == 1) check({tag, ".in_ready_calc"}, 32'(bus.div_in_ready), 32'd0);
            if (bus.div_out_valid) break;
        end
    endtask

    task automatic consume();
        bus.div_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.div_out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        int lat;
        start_op(sgn, a, b);
        wait_done(tag, lat);
        check({tag, ".lat"}, 32'(lat), 32'd32);
        check({tag, ".q"}, bus.div_quotient, eq);
        check({tag, ".r"}, bus.div_remainder, er);
        consume();
        check({tag, ".idle"}, 32'(bus.div_in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic seen;
        logic sgn;
        logic [31:0] a, b;
        logic signed [31:0] sa, sb;

        bus.div_in_valid  = 1'b0;
        bus.div_signed    = 1'b0;
        bus.div_src1      = '0;
        bus.div_src2      = '0;
        bus.div_out_ready = 1'b0;
        bus.div_flush     = 1'b0;
        reset             = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.in_ready",  32'(bus.div_in_ready),  32'd1);
        check("rst.out_valid", 32'(bus.div_out_valid), 32'd0);
        check("rst.busy",      32'(bus.div_busy),      32'd0);
        check("rst.q",         bus.div_quotient,       32'd0);
        check("rst.r",         bus.div_remainder,      32'd0);
        reset = 1'b0;

        // Directed vectors
        run_op("divu_100_7",  1'b0, 32'd100,        32'd7,          32'd14,         32'd2);
        run_op("div_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF);
        run_op("div_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1);
        run_op("div_min_m1",  1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0);
        run_op("divu_5_0",    1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5);
        run_op("div_5_0",     1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5);
        run_op("div_m5_0",    1'b1, 32'hFFFFFFFB,   32'd0,          32'd1,          32'hFFFFFFFB);
        run_op("div_m100_m7", 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE);
        run_op("divu_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0);
        run_op("divu_min_m1", 1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000);
        run_op("divu_3_10",   1'b0, 32'd3,          32'd10,         32'd0,          32'd3);

        // Busy goes high as soon as a request is presented in IDLE.
        @(negedge clk);
        bus.div_in_valid = 1'b1;
        bus.div_src1 = 32'd9; bus.div_src2 = 32'd2; bus.div_signed = 1'b0;
        #1 check("busy.req", 32'(bus.div_busy), 32'd1);
        bus.div_in_valid = 1'b0;

        // A flush in the same cycle as a request wins, so nothing is accepted.
        @(negedge clk);
        bus.div_in_valid = 1'b1;
        bus.div_flush    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.div_in_valid = 1'b0;
        bus.div_flush    = 1'b0;
        check("flush_vs_acc.in_ready", 32'(bus.div_in_ready), 32'd1);

        // Flush during CALC cycle 10
        start_op(1'b0, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        bus.div_flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.div_flush = 1'b0;
        check("flush.in_ready",  32'(bus.div_in_ready),  32'd1);
        check("flush.out_valid", 32'(bus.div_out_valid), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.div_out_valid) seen = 1'b1;
        end
        check("flush.never_valid", 32'(seen), 32'd0);
        run_op("after_flush", 1'b0, 32'd1000, 32'd7, 32'd142, 32'd6);

        // DONE held with ready low; later inputs must not disturb it.
        start_op(1'b0, 32'd1000, 32'd3);
        wait_done("hold", lat);
        for (int i = 0; i < 5; i++) begin
            bus.div_src1 = $urandom;
            bus.div_src2 = $urandom;
            @(posedge clk);
            @(negedge clk);
            check("hold.valid", 32'(bus.div_out_valid), 32'd1);
            check("hold.q",     bus.div_quotient,       32'd333);
            check("hold.r",     bus.div_remainder,      32'd1);
        end
        // Consume with the next request already pending. That request is accepted one cycle later.
        bus.div_in_valid  = 1'b1;
        bus.div_signed    = 1'b0;
        bus.div_src1      = 32'd50;
        bus.div_src2      = 32'd6;
        bus.div_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.div_out_ready = 1'b0;
        check("b2b.idle_first", 32'(bus.div_in_ready), 32'd1);
        check("b2b.busy",       32'(bus.div_busy),     32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.div_in_valid = 1'b0;
        check("b2b.accepted", 32'(bus.div_in_ready), 32'd0);
        wait_done("b2b", lat);
        check("b2b.lat", 32'(lat), 32'd32);
        check("b2b.q", bus.div_quotient,  32'd8);
        check("b2b.r", bus.div_remainder, 32'd2);
        consume();

        // Reset in the middle of CALC
        start_op(1'b1, 32'hFFFFFF9C, 32'd7);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_calc.in_ready",  32'(bus.div_in_ready),  32'd1);
        check("rst_calc.out_valid", 32'(bus.div_out_valid), 32'd0);
        check("rst_calc.busy",      32'(bus.div_busy),      32'd0);
        check("rst_calc.q",         bus.div_quotient,       32'd0);
        check("rst_calc.r",         bus.div_remainder,      32'd0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.div_out_valid) seen = 1'b1;
        end
        check("rst_calc.never_valid", 32'(seen), 32'd0);

        // Random sweep against the language's / and % operators
        for (int k = 0; k < 1000; k++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 50);
            if (b == 32'd0) b = 32'd1;
            if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
            sa = a;
            sb = b;
            if (sgn) run_op("rnd_div",  sgn, a, b, sa / sb, sa % sb);
            else     run_op("rnd_divu", sgn, a, b, a / b,   a % b);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
